// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch-controller definitions: FSM encodings, reset PC and PC stride.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_fetch_ctrl_pkg;

    // IDLE: nothing outstanding; PEND: one predicted branch awaiting EX;
    // REDIRECT: mispredict seen while stalled, redirect waits for stall release.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PEND     = 2'd1,
        ST_REDIRECT = 2'd2
    } pc_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_STEP          = 4;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bundle: stall, ID branch/jump, EX resolution inputs and PC/flush/predictor outputs.
// Latency: n/a (wires only).
// Backpressure: n/a; stalls are carried as plain level signals.
interface pc_fetch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              icache_stall;
    logic              hazard_stall;
    logic              id_branch;
    logic              id_pred_taken;
    logic [ADDR_W-1:0] id_target;
    logic [ADDR_W-1:0] id_pc_plus4;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              ex_resolve;
    logic              ex_taken;
    logic [ADDR_W-1:0] pc;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              pred_update;
    logic              pred_outcome;
    logic [CNT_W-1:0]  mispredict_cnt;

    // master: pipeline side driving the controller
    modport master (
        output icache_stall, hazard_stall, id_branch, id_pred_taken, id_target,
               id_pc_plus4, jump, jump_target, ex_resolve, ex_taken,
        input  pc, flush_if_id, flush_id_ex, pred_update, pred_outcome, mispredict_cnt
    );

    // slave: the fetch controller itself
    modport slave (
        input  icache_stall, hazard_stall, id_branch, id_pred_taken, id_target,
               id_pc_plus4, jump, jump_target, ex_resolve, ex_taken,
        output pc, flush_if_id, flush_id_ex, pred_update, pred_outcome, mispredict_cnt
    );
endinterface

// File: rtl/pc_next_mux.sv
// Next-PC priority select: redirect > jump > predicted-taken branch > pc + 4 (wraps).
// Latency: combinational.
// Backpressure: none; the caller decides whether the result is loaded.
module pc_next_mux
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        // sequential fetch; the add drops the carry so the PC wraps naturally
        next_pc = pc + ADDR_W'(PC_STEP);
        if (redirect) begin
            next_pc = redirect_pc;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC controller: tracks one predicted branch, redirects and flushes on mispredict, counts mispredicts.
// Latency: redirect lands on pc one clock after an unstalled mispredict; flushes are combinational that cycle.
// Backpressure: icache_stall/hazard_stall freeze pc and the pending record; a stalled mispredict parks in REDIRECT.
// Ports: clk, rst_n (async active-low), bus (pc_fetch_ctrl_if.slave: stall, ID branch/jump, EX resolve in;
//        pc, flush_if_id, flush_id_ex, pred_update, pred_outcome, mispredict_cnt out).
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_fetch_ctrl_if.slave bus
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_mux;
    logic              pend_valid_q;
    logic              pend_pred_q;
    logic [ADDR_W-1:0] pend_alt_q;
    logic [CNT_W-1:0]  cnt_q;

    logic stall;
    logic mispredict;
    logic redirect_now;
    logic wrong_path;
    logic br_accept;
    logic jump_sel;
    logic br_taken_sel;

    assign stall        = bus.icache_stall | bus.hazard_stall;
    assign mispredict   = (state_q == ST_PEND) && pend_valid_q && bus.ex_resolve
                          && (bus.ex_taken != pend_pred_q);
    assign redirect_now = !stall && (mispredict || (state_q == ST_REDIRECT));
    // Whatever sits in ID behind a mispredicted branch was fetched down the wrong path.
    assign wrong_path   = mispredict || (state_q == ST_REDIRECT);
    assign br_accept    = bus.id_branch && !stall && !wrong_path;
    assign jump_sel     = bus.jump && !wrong_path;
    assign br_taken_sel = bus.id_branch && bus.id_pred_taken && !wrong_path;

    pc_next_mux #(.ADDR_W(ADDR_W)) u_next_mux (
        .redirect      (redirect_now),
        .redirect_pc   (pend_alt_q),
        .jump          (jump_sel),
        .jump_target   (bus.jump_target),
        .branch_taken  (br_taken_sel),
        .branch_target (bus.id_target),
        .pc            (pc_q),
        .next_pc       (pc_mux)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (br_accept) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (mispredict) begin
                    state_d = stall ? ST_REDIRECT : ST_IDLE;
                end else if (br_accept) begin
                    state_d = ST_PEND;
                end else if (bus.ex_resolve) begin
                    // Resolution completes in EX even when fetch is frozen.
                    state_d = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (!stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pred_q  <= 1'b0;
            pend_alt_q   <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= (state_d != ST_IDLE);
            if (!stall) begin
                pc_q <= pc_mux;
            end
            if (br_accept) begin
                pend_pred_q <= bus.id_pred_taken;
                pend_alt_q  <= bus.id_pred_taken ? bus.id_pc_plus4 : bus.id_target;
            end
            if (mispredict && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc             = pc_q;
    assign bus.flush_if_id    = redirect_now || (!stall && (jump_sel || br_taken_sel));
    assign bus.flush_id_ex    = redirect_now;
    assign bus.pred_update    = bus.ex_resolve && (state_q == ST_PEND);
    assign bus.pred_outcome   = bus.ex_taken;
    assign bus.mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: table-driven scenarios with a queue of expected {next pc, flags}.
// A second instance with a 2-bit counter sees identical stimulus and exercises saturation.
// Flags are sampled as {flush_if_id, flush_id_ex, pred_update, pred_outcome}.
module tb_pc_fetch_ctrl;
    import pc_fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.ADDR_W(32), .CNT_W(16)) dif ();
    pc_fetch_ctrl_if #(.ADDR_W(32), .CNT_W(2))  sif ();

    pc_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(dif));
    pc_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .CNT_W(2)) sat_dut (
        .clk(clk), .rst_n(rst_n), .bus(sif));

    assign sif.icache_stall  = dif.icache_stall;
    assign sif.hazard_stall  = dif.hazard_stall;
    assign sif.id_branch     = dif.id_branch;
    assign sif.id_pred_taken = dif.id_pred_taken;
    assign sif.id_target     = dif.id_target;
    assign sif.id_pc_plus4   = dif.id_pc_plus4;
    assign sif.jump          = dif.jump;
    assign sif.jump_target   = dif.jump_target;
    assign sif.ex_resolve    = dif.ex_resolve;
    assign sif.ex_taken      = dif.ex_taken;

    // ctl = {icache_stall, hazard_stall, id_branch, id_pred_taken, jump, ex_resolve, ex_taken}
    typedef struct packed {
        logic [6:0]  ctl;
        logic [31:0] tgt;
        logic [31:0] p4;
        logic [31:0] jt;
        logic [31:0] epc;
        logic [3:0]  efl;
    } row_t;

    logic [35:0] sb[$];
    int errors = 0;
    int checks = 0;

    task automatic idle_inputs();
        {dif.icache_stall, dif.hazard_stall, dif.id_branch, dif.id_pred_taken,
         dif.jump, dif.ex_resolve, dif.ex_taken} = 7'b0;
        dif.id_target   = 32'h0;
        dif.id_pc_plus4 = 32'h0;
        dif.jump_target = 32'h0;
    endtask

    task automatic apply(input row_t r);
        @(negedge clk);
        {dif.icache_stall, dif.hazard_stall, dif.id_branch, dif.id_pred_taken,
         dif.jump, dif.ex_resolve, dif.ex_taken} = r.ctl;
        dif.id_target   = r.tgt;
        dif.id_pc_plus4 = r.p4;
        dif.jump_target = r.jt;
        sb.push_back({r.epc, r.efl});
    endtask

    task automatic test_reset();
        row_t rows [3] = '{
            '{7'b0000000, 32'h0, 32'h0, 32'h0, 32'h4, 4'b0000},
            '{7'b0000000, 32'h0, 32'h0, 32'h0, 32'h8, 4'b0000},
            '{7'b0000000, 32'h0, 32'h0, 32'h0, 32'hC, 4'b0000}};
        logic [3:0]  fl;
        logic [35:0] e;
        repeat (2) @(negedge clk);
        checks++;
        if (dif.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", dif.pc); end
        checks++;
        if ({dif.flush_if_id, dif.flush_id_ex} !== 2'b00) begin
            errors++; $display("FAIL reset_flush got %b want 00", {dif.flush_if_id, dif.flush_id_ex});
        end
        checks++;
        if (dif.mispredict_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", dif.mispredict_cnt); end
        checks++;
        if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
        @(posedge clk); #1 rst_n = 1'b1;
        checks++;
        if (dif.pc !== 32'h0) begin errors++; $display("FAIL release_pc got %h want 0", dif.pc); end
        foreach (rows[i]) begin
            apply(rows[i]);
            #1 fl = {dif.flush_if_id, dif.flush_id_ex, dif.pred_update, dif.pred_outcome};
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({dif.pc, fl} !== e) begin
                errors++;
                $display("FAIL reset_seq[%0d] pc/flags got %h/%b want %h/%b", i, dif.pc, fl, e[35:4], e[3:0]);
            end
        end
    endtask

    task automatic test_branch_correct();
        row_t rows [4] = '{
            '{7'b0000100, 32'h0,  32'h0,  32'h10, 32'h10, 4'b1000},
            '{7'b0011000, 32'h40, 32'h14, 32'h0,  32'h40, 4'b1000},
            '{7'b0000011, 32'h0,  32'h0,  32'h0,  32'h44, 4'b0011},
            '{7'b0000010, 32'h0,  32'h0,  32'h0,  32'h48, 4'b0000}};
        logic [3:0]  fl;
        logic [35:0] e;
        foreach (rows[i]) begin
            apply(rows[i]);
            #1 fl = {dif.flush_if_id, dif.flush_id_ex, dif.pred_update, dif.pred_outcome};
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({dif.pc, fl} !== e) begin
                errors++;
                $display("FAIL branch_correct[%0d] pc/flags got %h/%b want %h/%b", i, dif.pc, fl, e[35:4], e[3:0]);
            end
        end
        checks++;
        if (dif.mispredict_cnt !== 16'd0) begin errors++; $display("FAIL correct_cnt got %0d want 0", dif.mispredict_cnt); end
    endtask

    task automatic test_mispredict();
        row_t rows [4] = '{
            '{7'b0000100, 32'h0,  32'h0,  32'h10,  32'h10, 4'b1000},
            '{7'b0011000, 32'h40, 32'h14, 32'h0,   32'h40, 4'b1000},
            '{7'b0011110, 32'h80, 32'h44, 32'h200, 32'h14, 4'b1110},
            '{7'b0000010, 32'h0,  32'h0,  32'h0,   32'h18, 4'b0000}};
        logic [3:0]  fl;
        logic [35:0] e;
        foreach (rows[i]) begin
            apply(rows[i]);
            #1 fl = {dif.flush_if_id, dif.flush_id_ex, dif.pred_update, dif.pred_outcome};
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({dif.pc, fl} !== e) begin
                errors++;
                $display("FAIL mispredict[%0d] pc/flags got %h/%b want %h/%b", i, dif.pc, fl, e[35:4], e[3:0]);
            end
        end
        checks++;
        if (dif.mispredict_cnt !== 16'd1) begin errors++; $display("FAIL mispredict_cnt got %0d want 1", dif.mispredict_cnt); end
        checks++;
        if (sif.mispredict_cnt !== 2'd1) begin errors++; $display("FAIL mispredict_sat_cnt got %0d want 1", sif.mispredict_cnt); end
    endtask

    task automatic test_not_taken();
        row_t rows [4] = '{
            '{7'b0010000, 32'h40,  32'h1C, 32'h0, 32'h1C,  4'b0000},
            '{7'b0000010, 32'h0,   32'h0,  32'h0, 32'h20,  4'b0010},
            '{7'b0010000, 32'h100, 32'h24, 32'h0, 32'h24,  4'b0000},
            '{7'b0000011, 32'h0,   32'h0,  32'h0, 32'h100, 4'b1111}};
        logic [3:0]  fl;
        logic [35:0] e;
        foreach (rows[i]) begin
            apply(rows[i]);
            #1 fl = {dif.flush_if_id, dif.flush_id_ex, dif.pred_update, dif.pred_outcome};
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({dif.pc, fl} !== e) begin
                errors++;
                $display("FAIL not_taken[%0d] pc/flags got %h/%b want %h/%b", i, dif.pc, fl, e[35:4], e[3:0]);
            end
        end
        checks++;
        if (dif.mispredict_cnt !== 16'd2) begin errors++; $display("FAIL not_taken_cnt got %0d want 2", dif.mispredict_cnt); end
    endtask

    task automatic test_back_to_back();
        row_t rows [3] = '{
            '{7'b0011000, 32'h200, 32'h104, 32'h0, 32'h200, 4'b1000},
            '{7'b0010011, 32'h300, 32'h204, 32'h0, 32'h204, 4'b0011},
            '{7'b0000011, 32'h0,   32'h0,   32'h0, 32'h300, 4'b1111}};
        logic [3:0]  fl;
        logic [35:0] e;
        foreach (rows[i]) begin
            apply(rows[i]);
            #1 fl = {dif.flush_if_id, dif.flush_id_ex, dif.pred_update, dif.pred_outcome};
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({dif.pc, fl} !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] pc/flags got %h/%b want %h/%b", i, dif.pc, fl, e[35:4], e[3:0]);
            end
        end
        checks++;
        if (sif.mispredict_cnt !== 2'd3) begin errors++; $display("FAIL b2b_sat_cnt got %0d want 3", sif.mispredict_cnt); end
    endtask

    task automatic test_stall_redirect();
        row_t rows [7] = '{
            '{7'b0100100, 32'h0,  32'h0,   32'h500, 32'h300, 4'b0000},
            '{7'b0011000, 32'h40, 32'h304, 32'h0,   32'h40,  4'b1000},
            '{7'b1000010, 32'h0,  32'h0,   32'h0,   32'h40,  4'b0010},
            '{7'b1000011, 32'h0,  32'h0,   32'h0,   32'h40,  4'b0001},
            '{7'b0100000, 32'h0,  32'h0,   32'h0,   32'h40,  4'b0000},
            '{7'b0000100, 32'h0,  32'h0,   32'h500, 32'h304, 4'b1100},
            '{7'b0000000, 32'h0,  32'h0,   32'h0,   32'h308, 4'b0000}};
        logic [3:0]  fl;
        logic [35:0] e;
        foreach (rows[i]) begin
            apply(rows[i]);
            #1 fl = {dif.flush_if_id, dif.flush_id_ex, dif.pred_update, dif.pred_outcome};
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({dif.pc, fl} !== e) begin
                errors++;
                $display("FAIL stall_redirect[%0d] pc/flags got %h/%b want %h/%b", i, dif.pc, fl, e[35:4], e[3:0]);
            end
            if (i == 2) begin
                checks++;
                if (dut.state_q !== ST_REDIRECT) begin
                    errors++; $display("FAIL stall_state got %0d want REDIRECT", dut.state_q);
                end
            end
        end
        checks++;
        if (dif.mispredict_cnt !== 16'd4) begin errors++; $display("FAIL stall_cnt got %0d want 4", dif.mispredict_cnt); end
        checks++;
        if (sif.mispredict_cnt !== 2'd3) begin errors++; $display("FAIL stall_sat_cnt got %0d want 3", sif.mispredict_cnt); end
    endtask

    task automatic test_wrap_saturate();
        row_t rows [5] = '{
            '{7'b0000100, 32'h0,  32'h0,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 4'b1000},
            '{7'b0000000, 32'h0,  32'h0,  32'h0,         32'h0,         4'b0000},
            '{7'b0000100, 32'h0,  32'h0,  32'h10,        32'h10,        4'b1000},
            '{7'b0011000, 32'h40, 32'h14, 32'h0,         32'h40,        4'b1000},
            '{7'b0000010, 32'h0,  32'h0,  32'h0,         32'h14,        4'b1110}};
        logic [3:0]  fl;
        logic [35:0] e;
        foreach (rows[i]) begin
            apply(rows[i]);
            #1 fl = {dif.flush_if_id, dif.flush_id_ex, dif.pred_update, dif.pred_outcome};
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({dif.pc, fl} !== e) begin
                errors++;
                $display("FAIL wrap_saturate[%0d] pc/flags got %h/%b want %h/%b", i, dif.pc, fl, e[35:4], e[3:0]);
            end
        end
        checks++;
        if (dif.mispredict_cnt !== 16'd5) begin errors++; $display("FAIL wrap_cnt got %0d want 5", dif.mispredict_cnt); end
        checks++;
        if (sif.mispredict_cnt !== 2'd3) begin errors++; $display("FAIL wrap_sat_cnt got %0d want 3", sif.mispredict_cnt); end
    endtask

    task automatic test_reset_redirect();
        row_t pre [2] = '{
            '{7'b0011000, 32'h40, 32'h18, 32'h0, 32'h40, 4'b1000},
            '{7'b1000010, 32'h0,  32'h0,  32'h0, 32'h40, 4'b0010}};
        row_t post [2] = '{
            '{7'b0000010, 32'h0, 32'h0, 32'h0, 32'h4, 4'b0000},
            '{7'b0000000, 32'h0, 32'h0, 32'h0, 32'h8, 4'b0000}};
        logic [3:0]  fl;
        logic [35:0] e;
        foreach (pre[i]) begin
            apply(pre[i]);
            #1 fl = {dif.flush_if_id, dif.flush_id_ex, dif.pred_update, dif.pred_outcome};
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({dif.pc, fl} !== e) begin
                errors++;
                $display("FAIL reset_redirect_pre[%0d] pc/flags got %h/%b want %h/%b", i, dif.pc, fl, e[35:4], e[3:0]);
            end
        end
        checks++;
        if (dut.state_q !== ST_REDIRECT) begin errors++; $display("FAIL rr_state got %0d want REDIRECT", dut.state_q); end
        @(negedge clk); rst_n = 1'b0;
        #1;
        checks++;
        if (dif.pc !== 32'h0) begin errors++; $display("FAIL rr_pc got %h want 0", dif.pc); end
        checks++;
        if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rr_state_rst got %0d want IDLE", dut.state_q); end
        checks++;
        if ({dif.mispredict_cnt, sif.mispredict_cnt} !== 18'd0) begin
            errors++; $display("FAIL rr_cnt got %0d/%0d want 0/0", dif.mispredict_cnt, sif.mispredict_cnt);
        end
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({dif.pc, dif.flush_if_id, dif.flush_id_ex} !== 34'h0) begin
            errors++; $display("FAIL rr_release pc/flush got %h/%b want 0/00", dif.pc, {dif.flush_if_id, dif.flush_id_ex});
        end
        foreach (post[i]) begin
            apply(post[i]);
            #1 fl = {dif.flush_if_id, dif.flush_id_ex, dif.pred_update, dif.pred_outcome};
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({dif.pc, fl} !== e) begin
                errors++;
                $display("FAIL reset_redirect_post[%0d] pc/flags got %h/%b want %h/%b", i, dif.pc, fl, e[35:4], e[3:0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_branch_correct();
        test_mispredict();
        test_not_taken();
        test_back_to_back();
        test_stall_redirect();
        test_wrap_saturate();
        test_reset_redirect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of all PC and target buses.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-003 Parameter CNT_W, default 16, width of the mispredict counter.
REQ-004 Ports SHALL be:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- icache_stall  in  1  I-cache miss; freeze the fetch PC.
- hazard_stall  in  1  load-use stall from hazard unit; freeze the fetch PC.
- id_branch  in  1  ID-stage instruction is a conditional branch (beq).
- id_pred_taken  in  1  predictor decision for the ID branch.
- id_target  in  ADDR_W  branch target computed in ID.
- id_pc_plus4  in  ADDR_W  fall-through address of the ID branch.
- jump  in  1  ID-stage unconditional jump.
- jump_target  in  ADDR_W  jump destination.
- ex_resolve  in  1  EX stage holds the branch recorded last, outcome valid.
- ex_taken  in  1  actual outcome (operands equal).
- pc  out  ADDR_W  current fetch address.
- flush_if_id  out  1  squash IF/ID register.
- flush_id_ex  out  1  squash ID/EX register.
- pred_update  out  1  update strobe to predictor (its branch input).
- pred_outcome  out  1  actual outcome to predictor (its equal_or_not input).
- mispredict_cnt  out  CNT_W  saturating mispredict count.

Function
REQ-005 stall = icache_stall OR hazard_stall; while stall is high and no redirect is due, pc, state and pending record SHALL hold.
REQ-006 Pending record: pend_valid, pend_pred, pend_alt (alternate address = id_pc_plus4 if predicted taken, else id_target).
REQ-007 FSM states: IDLE (no unresolved branch), PEND (one branch predicted, awaiting EX), REDIRECT (mispredict detected, redirect waiting on stall).
REQ-008 IDLE -> PEND when id_branch high and not stall; record captured same edge.
REQ-009 PEND with ex_resolve and ex_taken == pend_pred (correct): -> PEND if a new id_branch is accepted that cycle, else IDLE.
REQ-010 PEND with ex_resolve and ex_taken != pend_pred: if not stall, pc <= pend_alt next edge, flush_if_id and flush_id_ex high that cycle, -> IDLE; if stall, -> REDIRECT holding pend_alt.
REQ-011 REDIRECT: on first cycle with stall low, pc <= pend_alt, both flushes high that cycle, -> IDLE; ex_resolve ignored in this state.
REQ-012 On a mispredict, a simultaneous id_branch or jump is wrong-path and SHALL be discarded.
REQ-013 Next-PC priority (non-stall): mispredict redirect > jump (jump_target, flush_if_id only) > id_branch with id_pred_taken (id_target, flush_if_id only) > pc + 4.
REQ-014 pc + 4 SHALL wrap modulo 2^ADDR_W.
REQ-015 pred_update = ex_resolve AND state == PEND, combinational; pred_outcome = ex_taken.
REQ-016 mispredict_cnt SHALL increment by 1 per detected mispredict, saturating at 2^CNT_W - 1.
REQ-017 ex_resolve in IDLE SHALL be ignored (no update, no flush).
REQ-018 Redirect latency: exactly one clock from mispredict detection (stall low) to pc = pend_alt.

Reset
REQ-019 rst_n low SHALL asynchronously set pc = RESET_PC, state = IDLE, pend_valid = 0, mispredict_cnt = 0, flushes = 0.
REQ-020 Reset asserted mid-PEND or mid-REDIRECT SHALL discard the pending redirect; first fetch after release is RESET_PC.

Structure
REQ-021 State encodings (IDLE/PEND/REDIRECT) and RESET_PC default SHALL live in the shared CPU package.
REQ-022 One sub-module, pc_next_mux, SHALL implement the REQ-013 priority select combinationally.

Verification
REQ-023 Reset release, no stalls -> pc sequence 0x0, 0x4, 0x8; cnt = 0.
REQ-024 id_branch at pc 0x10, pred taken, target 0x40; next cycle ex_taken = 1 -> pc 0x40, no flush_id_ex, pred_update = 1, pred_outcome = 1.
REQ-025 Same branch, pred taken, ex_taken = 0 -> pc 0x14 one cycle later, both flushes pulse once, cnt = 1.
REQ-026 Mispredict with icache_stall high 3 cycles -> state REDIRECT, pc held, then pc = pend_alt and flushes on first unstalled cycle.
REQ-027 cnt preset to 0xFFFF, another mispredict -> cnt stays 0xFFFF; pc at 0xFFFF_FFFC, no branch -> pc 0x0.
REQ-028 rst_n low while in REDIRECT -> pc = RESET_PC immediately, no flush after release.
